// File: rtl/vga_write_arbiter_pkg.sv
// Shared definitions for the VGA write arbiter.
// Holds the default image geometry, FIFO depth, colour/coordinate/address
// widths, the arbitration FSM state encoding, the buffered write-entry
// layout and the multiplier-free address helper.
package vga_write_arbiter_pkg;

  localparam int unsigned IMG_W_DEF      = 100;
  localparam int unsigned IMG_H_DEF      = 100;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned COLOR_W        = 3;
  localparam int unsigned COORD_W        = 8;
  localparam int unsigned ADDR_W         = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } wr_entry_t;

  // row*img_w + col as a sum of shifted copies of row, one per set bit of
  // img_w (for 100: (row<<6)+(row<<5)+(row<<2)). img_w is a constant at
  // every call site, so this reduces to a fixed adder tree.
  function automatic logic [ADDR_W-1:0] calc_addr(
    input logic [COORD_W-1:0] row,
    input logic [COORD_W-1:0] col,
    input int unsigned        img_w
  );
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(col);
    for (int b = 0; b < int'(ADDR_W); b++) begin
      if (img_w[b]) acc = acc + (ADDR_W'(row) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Bus bundle between the VGA write arbiter and its surroundings:
//   CPU write side : iWriteReq, iCol, iRow, iColor -> oStall, oRangeErr
//   Scanout side   : iReadReq, iReadCol, iReadRow  -> oReadData, oReadValid
//   VRAM side      : oVramAddr, oVramWe, oVramWData <- iVramRData
// The arbiter uses the slave modport; whatever drives the requests and
// models the VRAM uses the master modport.
interface vga_write_arbiter_if;
  import vga_write_arbiter_pkg::*;

  logic                iWriteReq;
  logic [COORD_W-1:0]  iCol;
  logic [COORD_W-1:0]  iRow;
  logic [COLOR_W-1:0]  iColor;
  logic                oStall;
  logic                oRangeErr;

  logic                iReadReq;
  logic [COORD_W-1:0]  iReadCol;
  logic [COORD_W-1:0]  iReadRow;
  logic [COLOR_W-1:0]  oReadData;
  logic                oReadValid;

  logic [ADDR_W-1:0]   oVramAddr;
  logic                oVramWe;
  logic [COLOR_W-1:0]  oVramWData;
  logic [COLOR_W-1:0]  iVramRData;

  modport slave (
    input  iWriteReq, iCol, iRow, iColor, iReadReq, iReadCol, iReadRow, iVramRData,
    output oStall, oRangeErr, oReadData, oReadValid, oVramAddr, oVramWe, oVramWData
  );

  modport master (
    output iWriteReq, iCol, iRow, iColor, iReadReq, iReadCol, iReadRow, iVramRData,
    input  oStall, oRangeErr, oReadData, oReadValid, oVramAddr, oVramWe, oVramWData
  );

endinterface

// File: rtl/vga_write_fifo.sv
// Small synchronous FIFO buffering CPU pixel writes.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push, i_data  : write an entry (ignored while full)
//   i_pop           : consume the head entry (ignored while empty)
//   o_data          : current head entry (valid while not empty)
//   o_full, o_empty : occupancy flags; o_full is a register
//   o_count         : number of stored entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module vga_write_fifo #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;

  logic              w_do_push;
  logic              w_do_pop;
  logic [CW-1:0]     w_count_next;

  assign w_do_push    = i_push && !r_full;
  assign w_do_pop     = i_pop && (r_count != '0);
  assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Head is read combinationally so a pop can drive the VRAM in the same cycle.
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates one single-port synchronous VRAM between scanout reads
// (strict priority) and buffered CPU pixel writes.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : vga_write_arbiter_if.slave (CPU write, scanout read, VRAM)
// Each cycle the FSM picks READ if a scanout read is requested, else WRITE
// if a buffered write is waiting (popping it), else IDLE. VRAM controls are
// registered, so a write is seen on oVramWe two cycles after its request.
module vga_write_arbiter
  import vga_write_arbiter_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_write_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_e         r_state;
  logic               r_range_err;
  logic               r_read_valid;
  logic [ADDR_W-1:0]  r_vram_addr;
  logic               r_vram_we;
  logic [COLOR_W-1:0] r_vram_wdata;

  logic               w_in_range;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_fifo_count;
  wr_entry_t          w_wr_entry;
  wr_entry_t          w_head;
  logic [ADDR_W-1:0]  w_rd_addr;

  assign w_in_range = ({1'b0, bus.iCol} < IMG_W[COORD_W:0]) &&
                      ({1'b0, bus.iRow} < IMG_H[COORD_W:0]);

  // While stalled, requests are neither pushed nor range-checked.
  assign w_push = bus.iWriteReq && !w_full && w_in_range;
  assign w_pop  = !bus.iReadReq && !w_empty;

  assign w_wr_entry.addr  = calc_addr(bus.iRow, bus.iCol, IMG_W);
  assign w_wr_entry.color = bus.iColor;
  assign w_rd_addr        = calc_addr(bus.iReadRow, bus.iReadCol, IMG_W);

  vga_write_fifo #(
    .DATA_W ($bits(wr_entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_range_err  <= 1'b0;
      r_read_valid <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_we    <= 1'b0;
      r_vram_wdata <= '0;
    end else begin
      r_range_err  <= bus.iWriteReq && !w_full && !w_in_range;
      // RAM returns data one cycle after the READ cycle presents the address.
      r_read_valid <= (r_state == ST_READ);
      if (bus.iReadReq) begin
        r_state     <= ST_READ;
        r_vram_addr <= w_rd_addr;
        r_vram_we   <= 1'b0;
      end else if (w_fifo_count != '0) begin
        // Same condition as w_pop, so the head popped here is what we drive.
        r_state      <= ST_WRITE;
        r_vram_addr  <= w_head.addr;
        r_vram_wdata <= w_head.color;
        r_vram_we    <= 1'b1;
      end else begin
        r_state   <= ST_IDLE;
        r_vram_we <= 1'b0;
      end
    end
  end

  assign bus.oStall     = w_full;
  assign bus.oRangeErr  = r_range_err;
  assign bus.oReadValid = r_read_valid;
  // Read data comes straight from the RAM port, gated so it is 0 when idle.
  assign bus.oReadData  = r_read_valid ? bus.iVramRData : '0;
  assign bus.oVramAddr  = r_vram_addr;
  assign bus.oVramWe    = r_vram_we;
  assign bus.oVramWData = r_vram_wdata;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter with a behavioural 1-cycle VRAM.
module tb_vga_write_arbiter;
  import vga_write_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  vga_write_arbiter_if bus ();

  vga_write_arbiter #(
    .IMG_W      (100),
    .IMG_H      (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port VRAM, read-first, 1-cycle read latency.
  logic [2:0] vram [16384];
  always @(posedge clk) begin
    if (bus.oVramWe) vram[bus.oVramAddr] <= bus.oVramWData;
    bus.iVramRData <= vram[bus.oVramAddr];
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic req, input int col, input int row, input int color);
    bus.iWriteReq = req;
    bus.iCol      = col[7:0];
    bus.iRow      = row[7:0];
    bus.iColor    = color[2:0];
  endtask

  task automatic set_rd(input logic req, input int col, input int row);
    bus.iReadReq = req;
    bus.iReadCol = col[7:0];
    bus.iReadRow = row[7:0];
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_stall"}, bus.oStall,     0);
    check_vec({tag, "_rerr"},  bus.oRangeErr,  0);
    check_vec({tag, "_rval"},  bus.oReadValid, 0);
    check_vec({tag, "_rdata"}, bus.oReadData,  0);
    check_vec({tag, "_we"},    bus.oVramWe,    0);
    check_vec({tag, "_addr"},  bus.oVramAddr,  0);
    check_vec({tag, "_wdata"}, bus.oVramWData, 0);
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) vram[a] = 3'd0;
    bus.iVramRData = 3'd0;
    set_wr(0, 0, 0, 0);
    set_rd(0, 0, 0);

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // First write: (col 5,row 2) -> 205, visible two cycles after request
    set_wr(1, 5, 2, 7);
    tick();
    set_wr(0, 0, 0, 0);
    check_vec("wr1_we_early", bus.oVramWe, 0);
    tick();
    check_vec("wr1_we",    bus.oVramWe,    1);
    check_vec("wr1_addr",  bus.oVramAddr,  205);
    check_vec("wr1_wdata", bus.oVramWData, 7);
    tick();
    check_vec("wr1_we_off", bus.oVramWe, 0);

    // Out-of-range column and row: no push, one-cycle error pulse
    set_wr(1, 100, 0, 3);
    tick();
    set_wr(0, 0, 0, 0);
    check_vec("col_oor_rerr", bus.oRangeErr, 1);
    tick();
    check_vec("col_oor_rerr_off", bus.oRangeErr, 0);
    check_vec("col_oor_nowe",     bus.oVramWe,   0);
    set_wr(1, 0, 100, 1);
    tick();
    set_wr(0, 0, 0, 0);
    check_vec("row_oor_rerr", bus.oRangeErr, 1);
    tick();
    check_vec("row_oor_nowe", bus.oVramWe, 0);

    // Last valid pixel (99,99) -> 9999
    set_wr(1, 99, 99, 5);
    tick();
    set_wr(0, 0, 0, 0);
    check_vec("corner_rerr", bus.oRangeErr, 0);
    tick();
    check_vec("corner_we",    bus.oVramWe,    1);
    check_vec("corner_addr",  bus.oVramAddr,  9999);
    check_vec("corner_wdata", bus.oVramWData, 5);
    tick();

    // Write 2 to location 100, then read it back via (col 0,row 1)
    set_wr(1, 0, 1, 2);
    tick();
    set_wr(0, 0, 0, 0);
    tick();
    check_vec("prel_addr", bus.oVramAddr, 100);
    set_rd(1, 0, 1);
    tick();
    set_rd(0, 0, 0);
    check_vec("rd_we",        bus.oVramWe,    0);
    check_vec("rd_addr",      bus.oVramAddr,  100);
    check_vec("rd_val_early", bus.oReadValid, 0);
    tick();
    check_vec("rd_val",   bus.oReadValid, 1);
    check_vec("rd_data",  bus.oReadData,  2);
    tick();
    check_vec("rd_val_off", bus.oReadValid, 0);

    // Reads hold off writes; FIFO fills, 5th write ignored, drain in order
    set_rd(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_wr(1, i, 0, i + 1);
      tick();
      check_vec($sformatf("hold_we_%0d", i), bus.oVramWe, 0);
      if (i == 2) check_vec("hold_stall_3", bus.oStall, 0);
      if (i == 3) check_vec("hold_stall_4", bus.oStall, 1);
      if (i == 4) begin
        check_vec("hold_stall_5", bus.oStall,    1);
        check_vec("hold_rerr_5",  bus.oRangeErr, 0);
      end
    end
    set_wr(0, 0, 0, 0);
    set_rd(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec($sformatf("drain_we_%0d", i),    bus.oVramWe,    1);
      check_vec($sformatf("drain_addr_%0d", i),  bus.oVramAddr,  i);
      check_vec($sformatf("drain_wdata_%0d", i), bus.oVramWData, i + 1);
      if (i == 0) check_vec("drain_stall", bus.oStall, 0);
    end
    tick();
    check_vec("drain_done", bus.oVramWe, 0);

    // Full FIFO, push and pop together: push dropped, three entries remain
    set_rd(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      set_wr(1, 10 + i, 3, i + 2);
      tick();
    end
    set_wr(0, 0, 0, 0);
    check_vec("pp_full", bus.oStall, 1);
    set_rd(0, 0, 0);
    set_wr(1, 50, 3, 7);
    tick();
    set_wr(0, 0, 0, 0);
    check_vec("pp_stall", bus.oStall,     0);
    check_vec("pp_we",    bus.oVramWe,    1);
    check_vec("pp_addr",  bus.oVramAddr,  310);
    check_vec("pp_wdata", bus.oVramWData, 2);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_vec($sformatf("pp_we_%0d", i),    bus.oVramWe,    1);
      check_vec($sformatf("pp_addr_%0d", i),  bus.oVramAddr,  310 + i);
      check_vec($sformatf("pp_wdata_%0d", i), bus.oVramWData, i + 2);
    end
    tick();
    check_vec("pp_no_extra", bus.oVramWe, 0);

    // Reset mid-drain: outputs clear at once, buffered writes discarded
    set_rd(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_wr(1, 20 + i, 4, i + 1);
      tick();
    end
    set_wr(0, 0, 0, 0);
    set_rd(0, 0, 0);
    tick();
    check_vec("mid_we",   bus.oVramWe,   1);
    check_vec("mid_addr", bus.oVramAddr, 420);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec($sformatf("post_rst_we_%0d", i), bus.oVramWe, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
